// File: rtl/msrv2_csr_pkg.sv
// msrv2_csr_pkg -- constants shared by the msrv2 machine-mode CSR file.
//   CSR address map, csr_op encodings, mstatus/mie bit positions, the
//   misa value and a helper that forms the CSRRW/CSRRS/CSRRC result.
package msrv2_csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // csr_op encodings
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // mie / mip bit positions
  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;
  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

  // RV32I, MXL=1
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  // New CSR value for a given op; NONE leaves the value untouched.
  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/msrv2_csr_counter64.sv
// msrv2_csr_counter64 -- 64-bit event counter with independently writable
// 32-bit halves (mcycle/minstret style).
//   clk_i    clock
//   rst_i    synchronous active-high reset, clears the count
//   inc_i    add one this cycle
//   wr_lo_i  load wdata_i into count[31:0] (wins over the increment)
//   wr_hi_i  load wdata_i into count[63:32] (wins over the increment)
//   wdata_i  write data
//   count_o  current count
module msrv2_csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] cnt_q, cnt_d;

  // Increment the full 64 bits first so the unwritten half still sees the
  // carry out of the old low word, then let a write override its half.
  always_comb begin
    cnt_d = cnt_q + {63'd0, inc_i};
    if (wr_lo_i) cnt_d[31:0]  = wdata_i;
    if (wr_hi_i) cnt_d[63:32] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/msrv2_csr_file.sv
// msrv2_csr_file -- machine-mode CSR register file of the msrv2 RV32I core,
// in the writeback stage beside the integer register file.
//   Executes CSRRW/CSRRS/CSRRC writes, provides combinational (pre-write)
//   read data, performs trap entry and MRET updates of mstatus/mepc/mcause,
//   and exposes the trap vector, MRET target and pending-interrupt flag.
// Configuration macro: MSRV2_CSR_COUNTERS_EN
//   defined   : mcycle/minstret 64-bit counters built (msrv2_csr_counter64 x2)
//   undefined : B00/B02/B80/B82 read 0, stay legal, writes ignored
// Ports
//   clk_in, rst_in                  clock, synchronous active-high reset
//   wr_en_in/csr_addr_in/csr_op_in/csr_wdata_in   CSR access
//   csr_rdata_out, illegal_csr_out  read data, illegal access flag
//   instret_inc_in                  instruction retired
//   trap_taken_in/trap_cause_in/trap_pc_in, mret_in   trap and return
//   ext_irq_in/timer_irq_in/sw_irq_in                 interrupt lines
//   trap_vector_out, epc_out, irq_pending_out         to fetch / control
module msrv2_csr_file
  import msrv2_csr_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] HART_ID      = 32'd0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [1:0]  csr_op_in,
  input  logic [31:0] csr_wdata_in,
  output logic [31:0] csr_rdata_out,
  output logic        illegal_csr_out,
  input  logic        instret_inc_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_cause_in,
  input  logic [31:0] trap_pc_in,
  input  logic        mret_in,
  input  logic        ext_irq_in,
  input  logic        timer_irq_in,
  input  logic        sw_irq_in,
  output logic [31:0] trap_vector_out,
  output logic [31:0] epc_out,
  output logic        irq_pending_out
);

  // Architectural state
  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q,      mie_d;
  logic [31:2] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:2] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;

  logic [63:0] cycle_cnt, instret_cnt;

  logic [31:0] mstatus_rd, mip_rd, rdata, wval;
  logic        addr_known, ro_write, illegal, wr_act;

  // MPP is hard-wired to M-mode (2'b11)
  always_comb begin
    mstatus_rd               = 32'h0000_1800;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
  end

  always_comb begin
    mip_rd           = '0;
    mip_rd[MIE_MSIE] = sw_irq_in;
    mip_rd[MIE_MTIE] = timer_irq_in;
    mip_rd[MIE_MEIE] = ext_irq_in;
  end

  // Address decode and read mux
  always_comb begin
    rdata      = '0;
    addr_known = 1'b1;
    case (csr_addr_in)
      CSR_MSTATUS:   rdata = mstatus_rd;
      CSR_MISA:      rdata = MISA_VAL;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = {mtvec_q, 2'b00};
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = {mepc_q, 2'b00};
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MIP:       rdata = mip_rd;
      CSR_MCYCLE:    rdata = cycle_cnt[31:0];
      CSR_MCYCLEH:   rdata = cycle_cnt[63:32];
      CSR_MINSTRET:  rdata = instret_cnt[31:0];
      CSR_MINSTRETH: rdata = instret_cnt[63:32];
      CSR_MVENDORID: rdata = '0;
      CSR_MARCHID:   rdata = '0;
      CSR_MIMPID:    rdata = '0;
      CSR_MHARTID:   rdata = HART_ID;
      default:       addr_known = 1'b0;
    endcase
  end

  // The F1x block is read-only by address encoding; misa is read-only too,
  // so a write to it is flagged. mip writes are silently ignored.
  assign ro_write = wr_en_in && (csr_op_in != CSR_OP_NONE) &&
                    ((csr_addr_in[11:10] == 2'b11) || (csr_addr_in == CSR_MISA));
  assign illegal  = !addr_known || ro_write;

  // Trap and MRET take priority; a CSR write colliding with either is dropped.
  assign wr_act = wr_en_in && (csr_op_in != CSR_OP_NONE) && !illegal &&
                  !trap_taken_in && !mret_in;

  assign wval = csr_apply(csr_op_in, rdata, csr_wdata_in);

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (trap_taken_in) begin
      mepc_d         = trap_pc_in[31:2];
      mcause_d       = trap_cause_in;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_in) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_act) begin
      case (csr_addr_in)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wval[MSTATUS_MIE];
          mstatus_mpie_d = wval[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wval & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = wval[31:2];
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval[31:2];
        CSR_MCAUSE:   mcause_d   = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_VECTOR[31:2];
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

`ifdef MSRV2_CSR_COUNTERS_EN
  msrv2_csr_counter64 u_mcycle (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .inc_i   (1'b1),
    .wr_lo_i (wr_act && (csr_addr_in == CSR_MCYCLE)),
    .wr_hi_i (wr_act && (csr_addr_in == CSR_MCYCLEH)),
    .wdata_i (wval),
    .count_o (cycle_cnt)
  );

  msrv2_csr_counter64 u_minstret (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .inc_i   (instret_inc_in),
    .wr_lo_i (wr_act && (csr_addr_in == CSR_MINSTRET)),
    .wr_hi_i (wr_act && (csr_addr_in == CSR_MINSTRETH)),
    .wdata_i (wval),
    .count_o (instret_cnt)
  );

  logic unused_bits;
  assign unused_bits = ^trap_pc_in[1:0];
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;

  logic unused_bits;
  assign unused_bits = ^{trap_pc_in[1:0], instret_inc_in};
`endif

  assign csr_rdata_out   = rdata;
  assign illegal_csr_out = illegal;
  assign trap_vector_out = {mtvec_q, 2'b00};
  assign epc_out         = {mepc_q, 2'b00};
  assign irq_pending_out = mstatus_mie_q && |(mie_q & mip_rd);

endmodule

// File: tb/tb_msrv2_csr_file.sv
// tb_msrv2_csr_file -- self-checking bench for msrv2_csr_file.
// Expected {illegal, rdata} pairs are queued as each access is driven and
// popped/compared once the combinational read settles.
module tb_msrv2_csr_file;

  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam logic [31:0] HID = 32'd3;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        wr_en = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] rdata;
  logic        illegal;
  logic        instret_inc = 1'b0;
  logic        trap_taken = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        mret = 1'b0;
  logic        ext_irq = 1'b0, timer_irq = 1'b0, sw_irq = 1'b0;
  logic [31:0] trap_vector, epc;
  logic        irq_pending;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  msrv2_csr_file #(.RESET_VECTOR(RV), .HART_ID(HID)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .wr_en_in        (wr_en),
    .csr_addr_in     (csr_addr),
    .csr_op_in       (csr_op),
    .csr_wdata_in    (csr_wdata),
    .csr_rdata_out   (rdata),
    .illegal_csr_out (illegal),
    .instret_inc_in  (instret_inc),
    .trap_taken_in   (trap_taken),
    .trap_cause_in   (trap_cause),
    .trap_pc_in      (trap_pc),
    .mret_in         (mret),
    .ext_irq_in      (ext_irq),
    .timer_irq_in    (timer_irq),
    .sw_irq_in       (sw_irq),
    .trap_vector_out (trap_vector),
    .epc_out         (epc),
    .irq_pending_out (irq_pending)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus, applied at the falling edge; side = {trap, mret, inc}
  task automatic drive(input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic we, input logic [2:0] side);
    @(negedge clk);
    csr_addr    = a;
    csr_op      = op;
    csr_wdata   = wd;
    wr_en       = we;
    trap_taken  = side[2];
    mret        = side[1];
    instret_inc = side[0];
  endtask

  task automatic access(input string nm, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic we, input logic [2:0] side,
                        input logic [31:0] exp_rd, input logic exp_ill);
    logic [32:0] e;
    drive(a, op, wd, we, side);
    exp_q.push_back({exp_ill, exp_rd});
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({illegal, rdata} !== e) begin
      errors++;
      $display("FAIL %s: got ill=%0b rd=%h expected ill=%0b rd=%h", nm, illegal, rdata, e[32], e[31:0]);
    end
  endtask

  // Same-cycle re-read at another address (no clock edge in between)
  task automatic peek(input string nm, input logic [11:0] a, input logic [31:0] exp_rd);
    logic [32:0] e;
    csr_addr = a;
    wr_en    = 1'b0;
    exp_q.push_back({1'b0, exp_rd});
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({illegal, rdata} !== e) begin
      errors++;
      $display("FAIL %s: got ill=%0b rd=%h expected ill=%0b rd=%h", nm, illegal, rdata, e[32], e[31:0]);
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    access("rst_mtvec",   12'h305, 2'b00, 0, 1'b0, 3'b000, RV, 1'b0);
    checks++;
    if (trap_vector !== RV || epc !== 32'h0 || irq_pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_outs: got tv=%h epc=%h irq=%0b expected tv=%h epc=0 irq=0", trap_vector, epc, irq_pending, RV);
    end
    access("rst_mstatus", 12'h300, 2'b00, 0, 1'b0, 3'b000, 32'h0000_1800, 1'b0);
    access("rst_mie",     12'h304, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    access("rst_mhartid", 12'hF14, 2'b00, 0, 1'b0, 3'b000, HID, 1'b0);
    access("rst_misa",    12'h301, 2'b00, 0, 1'b0, 3'b000, 32'h4000_0100, 1'b0);
  endtask

  task automatic test_rw_rs_rc;
    access("rw_scratch", 12'h340, 2'b01, 32'hDEAD_BEEF, 1'b1, 3'b000, 32'h0, 1'b0);
    access("rs_scratch", 12'h340, 2'b10, 32'h0000_0010, 1'b1, 3'b000, 32'hDEAD_BEEF, 1'b0);
    access("rc_scratch", 12'h340, 2'b11, 32'hDEAD_0000, 1'b1, 3'b000, 32'hDEAD_BEFF, 1'b0);
    access("rd_scratch", 12'h340, 2'b00, 0, 1'b0, 3'b000, 32'h0000_BEFF, 1'b0);
    // op 00 with write enable changes nothing
    access("nop_scratch", 12'h340, 2'b00, 32'hFFFF_FFFF, 1'b1, 3'b000, 32'h0000_BEFF, 1'b0);
    access("rd_scratch2", 12'h340, 2'b00, 0, 1'b0, 3'b000, 32'h0000_BEFF, 1'b0);
  endtask

  task automatic test_trap_mret;
    access("set_mie", 12'h300, 2'b01, 32'h0000_0008, 1'b1, 3'b000, 32'h0000_1800, 1'b0);
    trap_cause = 32'h8000_0007;
    trap_pc    = 32'h0000_0104;
    access("trap_wr", 12'h340, 2'b01, 32'h0000_1234, 1'b1, 3'b100, 32'h0000_BEFF, 1'b0);
    access("trap_mepc", 12'h341, 2'b00, 0, 1'b0, 3'b000, 32'h0000_0104, 1'b0);
    checks++;
    if (epc !== 32'h0000_0104) begin
      errors++;
      $display("FAIL trap_epc_out: got %h expected %h", epc, 32'h0000_0104);
    end
    access("trap_mcause",  12'h342, 2'b00, 0, 1'b0, 3'b000, 32'h8000_0007, 1'b0);
    access("trap_mstatus", 12'h300, 2'b00, 0, 1'b0, 3'b000, 32'h0000_1880, 1'b0);
    access("trap_scratch", 12'h340, 2'b00, 0, 1'b0, 3'b000, 32'h0000_BEFF, 1'b0);
    // MRET with a colliding write to mstatus: write is dropped
    access("mret_cyc",  12'h300, 2'b11, 32'h0000_0088, 1'b1, 3'b010, 32'h0000_1880, 1'b0);
    access("mret_mstatus", 12'h300, 2'b00, 0, 1'b0, 3'b000, 32'h0000_1888, 1'b0);
  endtask

  task automatic test_masks;
    access("wr_mtvec", 12'h305, 2'b01, 32'h0000_0203, 1'b1, 3'b000, RV, 1'b0);
    access("rd_mtvec", 12'h305, 2'b00, 0, 1'b0, 3'b000, 32'h0000_0200, 1'b0);
    checks++;
    if (trap_vector !== 32'h0000_0200) begin
      errors++;
      $display("FAIL tvec_out: got %h expected %h", trap_vector, 32'h0000_0200);
    end
    access("wr_mepc", 12'h341, 2'b01, 32'h0000_0107, 1'b1, 3'b000, 32'h0000_0104, 1'b0);
    access("rd_mepc", 12'h341, 2'b00, 0, 1'b0, 3'b000, 32'h0000_0104, 1'b0);
    access("wr_mie_all", 12'h304, 2'b01, 32'hFFFF_FFFF, 1'b1, 3'b000, 32'h0, 1'b0);
    access("rd_mie_all", 12'h304, 2'b00, 0, 1'b0, 3'b000, 32'h0000_0888, 1'b0);
  endtask

  task automatic test_illegal;
    access("ill_mhartid_wr", 12'hF14, 2'b01, 32'h5, 1'b1, 3'b000, HID, 1'b1);
    access("ill_mvendor_rs", 12'hF11, 2'b10, 32'h1, 1'b1, 3'b000, 32'h0, 1'b1);
    access("mhartid_rd_op",  12'hF14, 2'b01, 32'h5, 1'b0, 3'b000, HID, 1'b0);
    access("ill_7c0",        12'h7C0, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b1);
    access("ill_misa_wr",    12'h301, 2'b01, 32'h0, 1'b1, 3'b000, 32'h4000_0100, 1'b1);
    access("rd_misa",        12'h301, 2'b00, 0, 1'b0, 3'b000, 32'h4000_0100, 1'b0);
    access("mip_wr_legal",   12'h344, 2'b01, 32'hFFFF_FFFF, 1'b1, 3'b000, 32'h0, 1'b0);
    access("mip_rd",         12'h344, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
  endtask

  task automatic test_irq;
    access("wr_mie_mtie", 12'h304, 2'b01, 32'h0000_0080, 1'b1, 3'b000, 32'h0000_0888, 1'b0);
    ext_irq = 1'b1;
    access("mip_ext", 12'h344, 2'b00, 0, 1'b0, 3'b000, 32'h0000_0800, 1'b0);
    checks++;
    if (irq_pending !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: got %0b expected 0", irq_pending);
    end
    timer_irq = 1'b1;
    access("mip_both", 12'h344, 2'b00, 0, 1'b0, 3'b000, 32'h0000_0880, 1'b0);
    checks++;
    if (irq_pending !== 1'b1) begin
      errors++;
      $display("FAIL irq_timer: got %0b expected 1", irq_pending);
    end
    access("clr_mie", 12'h300, 2'b11, 32'h0000_0008, 1'b1, 3'b000, 32'h0000_1888, 1'b0);
    access("rd_mstatus_clr", 12'h300, 2'b00, 0, 1'b0, 3'b000, 32'h0000_1880, 1'b0);
    checks++;
    if (irq_pending !== 1'b0) begin
      errors++;
      $display("FAIL irq_cleared: got %0b expected 0", irq_pending);
    end
    ext_irq = 1'b0;
    timer_irq = 1'b0;
  endtask

  task automatic test_counters;
`ifdef MSRV2_CSR_COUNTERS_EN
    drive(12'hB80, 2'b01, 32'h0, 1'b1, 3'b000);
    drive(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b1, 3'b000);
    access("cyc_pre",  12'hB00, 2'b00, 0, 1'b0, 3'b000, 32'hFFFF_FFFF, 1'b0);
    access("cyc_wrap", 12'hB00, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    peek("cych_carry", 12'hB80, 32'h1);
    access("cyc_wr5",  12'hB00, 2'b01, 32'h5, 1'b1, 3'b000, 32'h1, 1'b0);
    access("cyc_is5",  12'hB00, 2'b00, 0, 1'b0, 3'b000, 32'h5, 1'b0);
    peek("cych_hold", 12'hB80, 32'h1);
    drive(12'hB82, 2'b01, 32'h0, 1'b1, 3'b000);
    drive(12'hB02, 2'b01, 32'h0, 1'b1, 3'b000);
    repeat (3) drive(12'h000, 2'b00, 0, 1'b0, 3'b001);
    access("instret_3", 12'hB02, 2'b00, 0, 1'b0, 3'b000, 32'h3, 1'b0);
    drive(12'hB02, 2'b01, 32'hFFFF_FFFF, 1'b1, 3'b001);
    access("instret_wr_wins", 12'hB02, 2'b00, 0, 1'b0, 3'b001, 32'hFFFF_FFFF, 1'b0);
    access("instret_wrap", 12'hB02, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    peek("instreth_carry", 12'hB82, 32'h1);
`else
    access("cyc_off_rd", 12'hB00, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    access("cyc_off_wr", 12'hB00, 2'b01, 32'h5, 1'b1, 3'b000, 32'h0, 1'b0);
    access("cyc_off_rd2", 12'hB00, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    access("instreth_off", 12'hB82, 2'b00, 0, 1'b0, 3'b001, 32'h0, 1'b0);
`endif
  endtask

  task automatic test_reset_midop;
    access("pre_rst_wr", 12'h340, 2'b01, 32'h0000_0055, 1'b1, 3'b000, 32'h0000_BEFF, 1'b0);
    trap_pc    = 32'h0000_0300;
    trap_cause = 32'h0000_000B;
    drive(12'h340, 2'b01, 32'h0000_0099, 1'b1, 3'b100);
    rst_in = 1'b1;
    drive(12'h000, 2'b00, 0, 1'b0, 3'b000);
    rst_in = 1'b0;
    access("midrst_scratch", 12'h340, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    access("midrst_mepc",    12'h341, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    access("midrst_mcause",  12'h342, 2'b00, 0, 1'b0, 3'b000, 32'h0, 1'b0);
    access("midrst_mstatus", 12'h300, 2'b00, 0, 1'b0, 3'b000, 32'h0000_1800, 1'b0);
    checks++;
    if (trap_vector !== RV || epc !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outs: got tv=%h epc=%h expected tv=%h epc=0", trap_vector, epc, RV);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_rw_rs_rc;
    test_trap_mret;
    test_masks;
    test_illegal;
    test_irq;
    test_counters;
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
